// File: rtl/guess_entry_ctrl.sv
// Guess entry front end: debounces the confirm button, captures SW as four BCD digits,
// range/uniqueness checks them and offers the guess over valid/ready. Option: GUESS_UNIQUE_CHECK_EN.
module guess_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] SW,
  input  logic        confirm_btn,
  input  logic        entry_en,
  input  logic        guess_ready,
  output logic [15:0] guess,
  output logic        guess_valid,
  output logic        reject,
  output logic [1:0]  err_code
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    CHECK,
    OFFER
  } state_t;

  state_t        state;
  logic          sync1, sync2;
  logic          level, level_d;
  logic [CW-1:0] cnt;
  logic          press;
  logic          range_err;
  logic          dup_err;

  // NOTE: every clocked block uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= confirm_btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Only the debounced rising edge is an event; releases are ignored.
  assign press = level & ~level_d;

  always_comb begin
    range_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (guess[i*4 +: 4] > 4'd9) range_err = 1'b1;
    end
  end

`ifdef GUESS_UNIQUE_CHECK_EN
  always_comb begin
    dup_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (guess[i*4 +: 4] == guess[j*4 +: 4]) dup_err = 1'b1;
      end
    end
  end
`else
  assign dup_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      guess       <= '0;
      guess_valid <= 1'b0;
      reject      <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      reject <= 1'b0;
      if (!entry_en) begin
        // Dropping entry_en abandons any pending offer.
        state       <= IDLE;
        guess_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= WAIT_PRESS;
          WAIT_PRESS: begin
            if (press) begin
              guess    <= SW;
              err_code <= 2'b00;
              state    <= CHECK;
            end
          end
          CHECK: begin
            if (range_err) begin
              err_code <= 2'b01;
              reject   <= 1'b1;
              state    <= WAIT_PRESS;
            end else if (dup_err) begin
              err_code <= 2'b10;
              reject   <= 1'b1;
              state    <= WAIT_PRESS;
            end else begin
              guess_valid <= 1'b1;
              state       <= OFFER;
            end
          end
          OFFER: begin
            if (guess_ready) begin
              guess_valid <= 1'b0;
              state       <= WAIT_PRESS;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Randomised self-checking bench for guess_entry_ctrl with DEBOUNCE_CYCLES=4.
module tb_guess_entry_ctrl;

  localparam int DC = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] SW = 16'h0000;
  logic        confirm_btn = 1'b0;
  logic        entry_en = 1'b0;
  logic        guess_ready = 1'b0;
  logic [15:0] guess;
  logic        guess_valid;
  logic        reject;
  logic [1:0]  err_code;

  int checks = 0;
  int failures = 0;

  guess_entry_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock),
    .reset(reset),
    .SW(SW),
    .confirm_btn(confirm_btn),
    .entry_en(entry_en),
    .guess_ready(guess_ready),
    .guess(guess),
    .guess_valid(guess_valid),
    .reject(reject),
    .err_code(err_code)
  );

  always #5 clock = ~clock;

  // Reference outcome of a clean press: 0 = offered, 1 = digit out of range, 2 = repeated digit.
  function automatic int model(input logic [15:0] sw);
    int d[4];
    for (int i = 0; i < 4; i++) d[i] = int'(sw[i*4 +: 4]);
    for (int i = 0; i < 4; i++) if (d[i] > 9) return 1;
`ifdef GUESS_UNIQUE_CHECK_EN
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i != j && d[i] == d[j]) return 2;
`endif
    return 0;
  endfunction

  // Hold the button for 'hold' cycles, release for 'rel' cycles, observing at each negedge.
  task automatic press_collect(input logic [15:0] sw, input int hold, input int rel,
                               output int n_rej, output int max_w, output int valid_at);
    int w;
    n_rej = 0; max_w = 0; valid_at = -1; w = 0;
    SW = sw;
    confirm_btn = 1'b1;
    for (int c = 0; c < hold + rel; c++) begin
      if (c == hold) confirm_btn = 1'b0;
      @(negedge clock);
      if (reject) begin
        w++;
        if (w == 1) n_rej++;
        if (w > max_w) max_w = w;
      end else begin
        w = 0;
      end
      if (guess_valid && valid_at < 0) valid_at = c;
      if (guess_valid) begin
        checks++;
        if (guess !== sw) begin
          failures++;
          $display("FAIL guess_while_valid got=%h exp=%h", guess, sw);
        end
      end
    end
  endtask

  task automatic check_outcome(input logic [15:0] sw, input int n_rej, input int max_w,
                               input int valid_at);
    int kind;
    logic [1:0] exp_err;
    kind = model(sw);
    exp_err = (kind == 1) ? 2'b01 : (kind == 2) ? 2'b10 : 2'b00;
    checks++;
    if (err_code !== exp_err) begin
      failures++;
      $display("FAIL err_code sw=%h got=%b exp=%b", sw, err_code, exp_err);
    end
    checks++;
    if (guess !== sw) begin
      failures++;
      $display("FAIL guess_captured got=%h exp=%h", guess, sw);
    end
    if (kind == 0) begin
      checks++;
      if (valid_at < 0 || n_rej != 0) begin
        failures++;
        $display("FAIL offer sw=%h valid_at=%0d rejects=%0d exp valid and 0 rejects", sw, valid_at, n_rej);
      end
    end else begin
      checks++;
      if (n_rej != 1 || max_w != 1 || valid_at >= 0) begin
        failures++;
        $display("FAIL reject_pulse sw=%h rejects=%0d width=%0d valid_at=%0d exp 1/1/-1",
                 sw, n_rej, max_w, valid_at);
      end
    end
  endtask

  // Keep guess_ready low for 'delay' cycles while the offer must persist, then accept.
  task automatic accept(input logic [15:0] sw, input int delay);
    for (int d = 0; d < delay; d++) begin
      @(negedge clock);
      checks++;
      if (guess_valid !== 1'b1 || guess !== sw) begin
        failures++;
        $display("FAIL offer_hold valid=%b guess=%h exp 1/%h", guess_valid, guess, sw);
      end
    end
    guess_ready = 1'b1;
    @(negedge clock);
    guess_ready = 1'b0;
    checks++;
    if (guess_valid !== 1'b0 || guess !== sw) begin
      failures++;
      $display("FAIL after_accept valid=%b guess=%h exp 0/%h", guess_valid, guess, sw);
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    checks++;
    if (guess !== 16'h0 || guess_valid !== 1'b0 || reject !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL reset_values guess=%h valid=%b reject=%b err=%b exp all 0",
               guess, guess_valid, reject, err_code);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    entry_en = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_basic();
    int n_rej, max_w, valid_at;
    press_collect(16'h1234, 12, 10, n_rej, max_w, valid_at);
    check_outcome(16'h1234, n_rej, max_w, valid_at);
    checks++;
    if (valid_at < 6 || valid_at > 11) begin
      failures++;
      $display("FAIL press_latency got=%0d exp 6..11", valid_at);
    end
    accept(16'h1234, 5);
  endtask

  task automatic test_bounce();
    logic [1:0] err_before;
    int n_rej, valid_seen;
    err_before = err_code;
    n_rej = 0; valid_seen = 0;
    SW = 16'h5678;
    for (int c = 0; c < 34; c++) begin
      confirm_btn = (c < 24) ? ((c / 2) % 2 == 0) : 1'b0;
      @(negedge clock);
      if (reject) n_rej++;
      if (guess_valid) valid_seen++;
    end
    checks++;
    if (n_rej != 0 || valid_seen != 0 || err_code !== err_before || guess !== 16'h1234) begin
      failures++;
      $display("FAIL bounce rejects=%0d valid=%0d err=%b guess=%h exp 0/0/%b/1234",
               n_rej, valid_seen, err_code, err_before, guess);
    end
  endtask

  task automatic test_range();
    int n_rej, max_w, valid_at;
    press_collect(16'h12A4, 12, 10, n_rej, max_w, valid_at);
    check_outcome(16'h12A4, n_rej, max_w, valid_at);
  endtask

  task automatic test_duplicate();
    int n_rej, max_w, valid_at;
    press_collect(16'h1231, 12, 10, n_rej, max_w, valid_at);
    check_outcome(16'h1231, n_rej, max_w, valid_at);
    if (model(16'h1231) == 0) accept(16'h1231, 1);
  endtask

  task automatic test_abort();
    int n_rej, max_w, valid_at, valid_seen;
    press_collect(16'h5678, 12, 10, n_rej, max_w, valid_at);
    check_outcome(16'h5678, n_rej, max_w, valid_at);
    entry_en = 1'b0;
    @(negedge clock);
    checks++;
    if (guess_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_drop valid=%b exp 0", guess_valid);
    end
    entry_en = 1'b1;
    guess_ready = 1'b1;
    valid_seen = 0;
    repeat (6) begin
      @(negedge clock);
      if (guess_valid) valid_seen++;
    end
    guess_ready = 1'b0;
    checks++;
    if (valid_seen != 0) begin
      failures++;
      $display("FAIL abort_no_reoffer valid_cycles=%0d exp 0", valid_seen);
    end
    press_collect(16'h9012, 12, 10, n_rej, max_w, valid_at);
    check_outcome(16'h9012, n_rej, max_w, valid_at);
    accept(16'h9012, 2);
  endtask

  task automatic wait_offer_after_reset(input logic [15:0] sw, input string name);
    int valid_at;
    valid_at = -1;
    for (int c = 0; c < 20 && valid_at < 0; c++) begin
      @(negedge clock);
      if (guess_valid) valid_at = c;
    end
    checks++;
    if (valid_at < 5 || guess !== sw) begin
      failures++;
      $display("FAIL %s valid_at=%0d guess=%h exp 5..19/%h", name, valid_at, guess, sw);
    end
  endtask

  task automatic test_reset_mid();
    SW = 16'h4321;
    confirm_btn = 1'b1;
    repeat (4) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (guess !== 16'h0 || guess_valid !== 1'b0 || reject !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL reset_mid_debounce guess=%h valid=%b reject=%b err=%b exp all 0",
               guess, guess_valid, reject, err_code);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_offer_after_reset(16'h4321, "held_press_after_reset");
    // Now in OFFER with the button still held.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (guess !== 16'h0 || guess_valid !== 1'b0 || reject !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL reset_in_offer guess=%h valid=%b reject=%b err=%b exp all 0",
               guess, guess_valid, reject, err_code);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_offer_after_reset(16'h4321, "held_press_after_offer_reset");
    confirm_btn = 1'b0;
    accept(16'h4321, 0);
    repeat (10) @(negedge clock);
  endtask

  task automatic test_random();
    int n_rej, max_w, valid_at;
    logic [15:0] sw;
    for (int it = 0; it < 16; it++) begin
      if (it % 2 == 0) begin
        for (int i = 0; i < 4; i++) sw[i*4 +: 4] = 4'($urandom_range(0, 11));
      end else begin
        bit used[10];
        for (int k = 0; k < 10; k++) used[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          int v;
          v = int'($urandom_range(0, 9));
          while (used[v]) v = (v + 1) % 10;
          used[v] = 1'b1;
          sw[i*4 +: 4] = 4'(v);
        end
      end
      press_collect(sw, 12, 10, n_rej, max_w, valid_at);
      check_outcome(sw, n_rej, max_w, valid_at);
      if (model(sw) == 0) accept(sw, int'($urandom_range(0, 4)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounce();
    test_range();
    test_duplicate();
    test_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
